// File: rtl/fir_pkg.sv
// Shared definitions for the FIR accumulation sequencer: data width,
// controller state encoding and the signed-overflow rule for a two-operand add.
package fir_pkg;

    localparam int DATA_W = 16;

    // Encoding 2'd3 is unused and steers back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Two's-complement overflow: operands share a sign and the sum's sign differs.
    function automatic logic signed_ovf(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] s
    );
        return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    endfunction

endpackage

// File: rtl/rca.sv
// 16-bit ripple-carry adder, carry-in tied low. ov is the signed overflow
// derived from the carries into and out of the sign bit.
module rca
    import fir_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] s,
    output logic              ov
);

    logic [DATA_W:0] c;

    // Carry chain built bit by bit, LSB first.
    always_comb begin
        c    = '0;
        s    = '0;
        for (int i = 0; i < DATA_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign ov = c[DATA_W] ^ c[DATA_W-1];

endmodule

// File: rtl/fir_acc_sched.sv
// Accumulation sequencer: requests NTAPS partial products by index, sums them
// through one shared rca adder and hands the finished sample downstream with a
// sticky signed-overflow flag.
module fir_acc_sched
    import fir_pkg::*;
#(
    parameter  int NTAPS = 8,
    localparam int CNT_W = $clog2(NTAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic [CNT_W-1:0]  tap_idx,
    input  logic              pp_valid,
    input  logic [DATA_W-1:0] pp_data,
    output logic              pp_ready,
    output logic              y_valid,
    output logic [DATA_W-1:0] y_data,
    input  logic              y_ready,
    output logic              ovf
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NTAPS - 1);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] acc_reg,   acc_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;
    logic              ovf_reg,   ovf_next;

    logic [DATA_W-1:0] sum;
    logic              rca_ov;
    logic              step_ovf;
    logic              accept;

    // Shared adder: running sum plus the incoming partial product.
    rca u_rca (
        .a  (acc_reg),
        .b  (pp_data),
        .s  (sum),
        .ov (rca_ov)
    );

    assign step_ovf = signed_ovf(acc_reg, pp_data, sum);
    assign accept   = pp_valid && (state_reg == ST_ACC);

    // State, accumulator, tap counter and overflow flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

    // The adder's own overflow output must agree with the sign-based rule.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            assert (rca_ov == step_ovf);
        end
    end

    // Next-state and datapath update; carry-out of the add is irrelevant for signed data.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ACC;
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                end
            end
            ST_ACC: begin
                if (pp_valid) begin
                    acc_next = sum;
                    ovf_next = ovf_reg | step_ovf;
                    if (cnt_reg == LAST) begin
                        state_next = ST_OUT;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ST_OUT: begin
                if (y_ready) begin
                    if (start) begin
                        state_next = ST_ACC;
                        acc_next   = '0;
                        cnt_next   = '0;
                        ovf_next   = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_reg == ST_ACC) || (state_reg == ST_OUT);
    assign pp_ready = (state_reg == ST_ACC);
    assign y_valid  = (state_reg == ST_OUT);
    assign y_data   = acc_reg;
    assign tap_idx  = cnt_reg;
    assign ovf      = ovf_reg;

endmodule

// File: tb/tb_fir_acc_sched.sv
// Bench for fir_acc_sched: a cycle model built from signed integer sums plus
// directed literal expectations from hand-worked samples.
module tb_fir_acc_sched;
    localparam int NTAPS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic [2:0]  tap_idx;
    logic        pp_valid = 1'b0;
    logic [15:0] pp_data = '0;
    logic        pp_ready;
    logic        y_valid;
    logic [15:0] y_data;
    logic        y_ready = 1'b0;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    fir_acc_sched #(.NTAPS(NTAPS)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .tap_idx(tap_idx),
        .pp_valid(pp_valid), .pp_data(pp_data), .pp_ready(pp_ready),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = waiting, 1 = collecting products, 2 = presenting.
    int   m_mode = 0;
    int   m_acc  = 0;
    int   m_cnt  = 0;
    bit   m_ovf  = 0;
    bit   started = 0;

    always @(posedge clk) begin
        int s;
        logic [15:0] w;
        started = 1;
        if (rst) begin
            m_mode = 0; m_acc = 0; m_cnt = 0; m_ovf = 0;
        end else if (m_mode == 0) begin
            if (start) begin m_mode = 1; m_acc = 0; m_cnt = 0; m_ovf = 0; end
        end else if (m_mode == 1) begin
            if (pp_valid) begin
                s = m_acc + int'($signed(pp_data));
                if (s > 32767 || s < -32768) m_ovf = 1;
                w = s[15:0];
                m_acc = int'($signed(w));
                if (m_cnt == NTAPS - 1) m_mode = 2;
                else m_cnt = m_cnt + 1;
            end
        end else begin
            if (y_ready) begin
                if (start) begin m_mode = 1; m_acc = 0; m_cnt = 0; m_ovf = 0; end
                else m_mode = 0;
            end
        end
    end

    // Every cycle: compare outputs with the model, mid-cycle.
    always @(negedge clk) begin
        logic [15:0] ey;
        if (started) begin
            ey = m_acc[15:0];
            chk("busy", 32'(busy), 32'(m_mode != 0));
            chk("pp_ready", 32'(pp_ready), 32'(m_mode == 1));
            chk("y_valid", 32'(y_valid), 32'(m_mode == 2));
            chk("tap_idx", 32'(tap_idx), 32'(m_cnt));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            if (m_mode == 2) chk("y_data", 32'(y_data), 32'(ey));
        end
    end

    logic [15:0] pp_vec [NTAPS];

    // One sample: optional start, feed products with a valid pattern, hold in
    // OUT for 'hold' cycles with start asserted, then handshake.
    task automatic run_sample(input int pat, input int hold, input bit chain,
                              input bit skip_start, input bit lit,
                              input logic [15:0] exp_y, input bit exp_ovf,
                              input bit mid_ovf);
        int cyc = 0;
        int k = 0;
        if (!skip_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("start_ovf_clr", 32'(ovf), 32'd0);
        chk("start_tap0", 32'(tap_idx), 32'd0);
        chk("start_ready", 32'(pp_ready), 32'd1);
        while (m_mode != 2 && cyc < 300) begin
            case (pat)
                0: pp_valid = 1'b1;
                1: pp_valid = ((k % 3) == 0);
                default: pp_valid = 1'($urandom_range(0, 1));
            endcase
            pp_data = pp_vec[m_cnt];
            @(posedge clk); #1;
            cyc++; k++;
            if (mid_ovf && k == 1) chk("ovf_after_add1", 32'(ovf), 32'd0);
            if (mid_ovf && k == 2) chk("ovf_after_add2", 32'(ovf), 32'd1);
        end
        pp_valid = 1'b0;
        if (cyc >= 300) chk("timeout_acc", 32'(cyc), 32'd0);
        if (lit) begin
            chk("y_data_lit", 32'(y_data), 32'(exp_y));
            chk("ovf_lit", 32'(ovf), 32'(exp_ovf));
            chk("y_valid_lit", 32'(y_valid), 32'd1);
            if (pat == 0) chk("latency", 32'(cyc), 32'(NTAPS));
        end
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            @(posedge clk); #1;
            if (lit) chk("hold_y_data", 32'(y_data), 32'(exp_y));
        end
        start   = chain;
        y_ready = 1'b1;
        @(posedge clk); #1;
        y_ready = 1'b0;
        start   = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_y_data", 32'(y_data), 32'd0);
        chk("reset_tap", 32'(tap_idx), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NTAPS; i++) pp_vec[i] = 16'(i + 1);
        run_sample(0, 0, 0, 0, 1, 16'h0024, 0, 0);

        for (int i = 0; i < NTAPS; i++) pp_vec[i] = 16'hFFFF;
        run_sample(0, 0, 0, 0, 1, 16'hFFF8, 0, 0);

        for (int i = 0; i < NTAPS; i++) pp_vec[i] = 16'h4000;
        run_sample(0, 0, 0, 0, 1, 16'h0000, 1, 1);

        for (int i = 0; i < NTAPS; i++) pp_vec[i] = 16'(i + 1);
        run_sample(1, 0, 0, 0, 1, 16'h0024, 0, 0);

        // Stall in OUT with start ignored, then chain straight into a new sample.
        run_sample(0, 5, 1, 0, 1, 16'h0024, 0, 0);
        for (int i = 0; i < NTAPS; i++) pp_vec[i] = 16'h0002;
        run_sample(0, 0, 0, 1, 1, 16'h0010, 0, 0);

        // Reset after four accepts discards the partial sum.
        for (int i = 0; i < NTAPS; i++) pp_vec[i] = 16'(i + 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pp_data = pp_vec[m_cnt];
            @(posedge clk); #1;
        end
        pp_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pp_ready", 32'(pp_ready), 32'd0);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        run_sample(0, 0, 0, 0, 1, 16'h0024, 0, 0);

        // Randomised samples, valid gaps, stalls and chaining checked by the model.
        for (int n = 0; n < 10; n++) begin
            bit ch;
            for (int i = 0; i < NTAPS; i++) pp_vec[i] = 16'($urandom);
            ch = (n > 0) && ($urandom_range(0, 1) == 1);
            run_sample(2, int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1) && n < 9,
                       (m_mode == 1), 0, 16'h0, 0, 0);
            if (ch && m_mode == 0) @(posedge clk);
            #0;
        end
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
